opr_sequencer: RTL and testbench

- Multi-cycle controller that executes PDP-8 OPR instructions (opcode 7) for the main CPU state machine.
- Takes one instruction per start/done handshake.
- Drives the 9-bit microcode field and the current AC/L into the combinational micro-instruction decoder, and registers the decoder results.
- Adds the operations the decoder does not perform: group-2 CLA/OSR/HLT, group-3 CLA/MQA/MQL with the MQ register, and the PC update including skip.

---
 rtl/opr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_opr_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/opr_sequencer.sv
// opr_sequencer: multi-cycle PDP-8 OPR executor (decode, group exec, MQ, PC/skip, halt); optional OPR_SEQ_PERF_EN adds group/skip counters
module opr_sequencer #(
    parameter int WORD_W  = 12,
    parameter int MICRO_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WORD_W-1:0]  ir,
    input  logic [WORD_W-1:0]  ac_in,
    input  logic               l_in,
    input  logic [WORD_W-1:0]  pc_in,
    input  logic [WORD_W-1:0]  sr_in,
    input  logic               cont,
    output logic [MICRO_W-1:0] dec_ir,
    output logic [WORD_W-1:0]  dec_ac,
    output logic               dec_l,
    input  logic [WORD_W-1:0]  dec_ac_micro,
    input  logic               dec_l_micro,
    input  logic               dec_skip,
    input  logic               dec_g1,
    input  logic               dec_g2,
    input  logic               dec_g3,
    output logic               ready,
    output logic               done,
    output logic [WORD_W-1:0]  ac_out,
    output logic               l_out,
    output logic [WORD_W-1:0]  pc_out,
    output logic [WORD_W-1:0]  mq_out,
    output logic               halted,
`ifdef OPR_SEQ_PERF_EN
    output logic [15:0]        cnt_g1,
    output logic [15:0]        cnt_g2,
    output logic [15:0]        cnt_g3,
    output logic [15:0]        cnt_skip,
`endif
    output logic               illegal
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALTED} state_t;
    state_t state;
    logic [2:0] op;
    logic [WORD_W-1:0] pc_q, sr_q, ac_m, t, ex_ac, ex_mq, pc_next;
    logic l_m, skip_m, g1_m, g2_m, g3_m, halt_pending;
    logic bad, mqa, mql, ex_l, ex_skip, ex_halt;

    // Group execution from the registered decoder results; a non-one-hot group set leaves state untouched
    always_comb begin
        bad     = !$onehot({g1_m, g2_m, g3_m});
        mqa     = dec_ir[6];
        mql     = dec_ir[4];
        t       = dec_ir[7] ? '0 : dec_ac;
        ex_ac   = bad ? dec_ac :
                  g1_m ? ac_m :
                  g2_m ? (t | (dec_ir[2] ? sr_q : '0)) :
                  (mqa && mql) ? mq_out :
                  mqa ? (t | mq_out) :
                  mql ? '0 : t;
        ex_l    = (g1_m && !bad) ? l_m : dec_l;
        ex_mq   = (g3_m && !bad && mql) ? t : mq_out;
        ex_skip = g2_m && !bad && skip_m;
        ex_halt = g2_m && !bad && dec_ir[1];
        pc_next = pc_q + WORD_W'(1) + WORD_W'(ex_skip);
    end

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ready        <= 1'b1;
            done         <= 1'b0;
            illegal      <= 1'b0;
            halted       <= 1'b0;
            halt_pending <= 1'b0;
            ac_out       <= '0;
            l_out        <= 1'b0;
            pc_out       <= '0;
            mq_out       <= '0;
            dec_ir       <= '0;
            dec_ac       <= '0;
            dec_l        <= 1'b0;
            op           <= '0;
            pc_q         <= '0;
            sr_q         <= '0;
            ac_m         <= '0;
            l_m          <= 1'b0;
            skip_m       <= 1'b0;
            g1_m         <= 1'b0;
            g2_m         <= 1'b0;
            g3_m         <= 1'b0;
`ifdef OPR_SEQ_PERF_EN
            cnt_g1       <= '0;
            cnt_g2       <= '0;
            cnt_g3       <= '0;
            cnt_skip     <= '0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dec_ir <= ir[MICRO_W-1:0];
                    op     <= ir[WORD_W-1:WORD_W-3];
                    dec_ac <= ac_in;
                    dec_l  <= l_in;
                    pc_q   <= pc_in;
                    sr_q   <= sr_in;
                    ready  <= 1'b0;
                    state  <= DECODE;
                end
                DECODE: begin
                    ac_m   <= dec_ac_micro;
                    l_m    <= dec_l_micro;
                    skip_m <= dec_skip;
                    g1_m   <= dec_g1;
                    g2_m   <= dec_g2;
                    g3_m   <= dec_g3;
                    if (op != 3'b111) begin
                        ac_out       <= dec_ac;
                        l_out        <= dec_l;
                        pc_out       <= pc_q + WORD_W'(1);
                        halt_pending <= 1'b0;
                        done         <= 1'b1;
                        illegal      <= 1'b1;
                        state        <= WB;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    ac_out       <= ex_ac;
                    l_out        <= ex_l;
                    mq_out       <= ex_mq;
                    pc_out       <= pc_next;
                    halt_pending <= ex_halt;
                    done         <= 1'b1;
                    illegal      <= bad;
                    state        <= WB;
`ifdef OPR_SEQ_PERF_EN
                    if (g1_m && !bad && cnt_g1 != 16'hFFFF) cnt_g1 <= cnt_g1 + 16'd1;
                    if (g2_m && !bad && cnt_g2 != 16'hFFFF) cnt_g2 <= cnt_g2 + 16'd1;
                    if (g3_m && !bad && cnt_g3 != 16'hFFFF) cnt_g3 <= cnt_g3 + 16'd1;
                    if (ex_skip && cnt_skip != 16'hFFFF) cnt_skip <= cnt_skip + 16'd1;
`endif
                end
                WB: begin
                    state  <= halt_pending ? HALTED : IDLE;
                    ready  <= !halt_pending;
                    halted <= halt_pending;
                end
                HALTED: if (cont) begin
                    state  <= IDLE;
                    halted <= 1'b0;
                    ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_opr_sequencer.sv
// tb_opr_sequencer: directed self-checking bench for opr_sequencer with a behavioural OPR decoder
module tb_opr_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0, l_in = 1'b0, kill = 1'b0;
    logic [11:0] ir = '0, ac_in = '0, pc_in = '0, sr_in = '0;
    logic [8:0] dec_ir;
    logic [11:0] dec_ac, dec_ac_micro, ac_out, pc_out, mq_out;
    logic dec_l, dec_l_micro, dec_skip, dec_g1, dec_g2, dec_g3;
    logic ready, done, l_out, halted, illegal;
`ifdef OPR_SEQ_PERF_EN
    logic [15:0] cnt_g1, cnt_g2, cnt_g3, cnt_skip;
`endif
    int n_checks = 0, n_fail = 0, lat;
    logic [12:0] la;
    logic s;

    opr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .ac_in(ac_in), .l_in(l_in),
        .pc_in(pc_in), .sr_in(sr_in), .cont(cont), .dec_ir(dec_ir), .dec_ac(dec_ac),
        .dec_l(dec_l), .dec_ac_micro(dec_ac_micro), .dec_l_micro(dec_l_micro),
        .dec_skip(dec_skip), .dec_g1(dec_g1), .dec_g2(dec_g2), .dec_g3(dec_g3),
        .ready(ready), .done(done), .ac_out(ac_out), .l_out(l_out), .pc_out(pc_out),
        .mq_out(mq_out), .halted(halted),
`ifdef OPR_SEQ_PERF_EN
        .cnt_g1(cnt_g1), .cnt_g2(cnt_g2), .cnt_g3(cnt_g3), .cnt_skip(cnt_skip),
`endif
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference micro-instruction decoder: group-1 CLA/CLL/CMA/CML/IAC, group-2 skip conditions
    always_comb begin
        la = {dec_ir[6] ? 1'b0 : dec_l, dec_ir[7] ? 12'o0 : dec_ac};
        if (dec_ir[5]) la[11:0] = ~la[11:0];
        if (dec_ir[4]) la[12] = ~la[12];
        if (dec_ir[0]) la = la + 13'd1;
        s = (dec_ir[6] & dec_ac[11]) | (dec_ir[5] & (dec_ac == 12'o0)) | (dec_ir[4] & dec_l);
        dec_g1 = !kill && !dec_ir[8];
        dec_g2 = !kill && dec_ir[8] && !dec_ir[0];
        dec_g3 = !kill && dec_ir[8] && dec_ir[0];
        dec_ac_micro = dec_g1 ? la[11:0] : dec_ac;
        dec_l_micro = dec_g1 ? la[12] : dec_l;
        dec_skip = dec_g2 && (dec_ir[3] ? !s : s);
    end

    task automatic run_op(input logic [11:0] i, input logic [11:0] a, input logic l,
                          input logic [11:0] p, input logic [11:0] sr);
        int k = 0;
        while (!ready && k < 20) begin @(posedge clk); #1; k++; end
        ir = i; ac_in = a; l_in = l; pc_in = p; sr_in = sr; start = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; start = 1'b0; lat++; end while (!done && lat < 10);
        if (!done) lat = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if ({done, illegal, halted} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {done, illegal, halted}); end
        n_checks++; if ({ac_out, l_out, pc_out, mq_out} !== 37'd0) begin n_fail++; $display("FAIL reset_regs got %o %b %o %o want 0", ac_out, l_out, pc_out, mq_out); end
        n_checks++; if ({dec_ir, dec_ac, dec_l} !== 22'd0) begin n_fail++; $display("FAIL reset_dec got %o %o %b want 0", dec_ir, dec_ac, dec_l); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_group1();
        run_op(12'o7301, 12'o4567, 1'b1, 12'o0200, 12'o0);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL g1_latency got %0d want 3", lat); end
        n_checks++; if ({ac_out, l_out, pc_out, illegal} !== {12'o0001, 1'b0, 12'o0201, 1'b0}) begin n_fail++; $display("FAIL g1_result got ac=%o l=%b pc=%o ill=%b want 0001 0 0201 0", ac_out, l_out, pc_out, illegal); end
        @(posedge clk); #1;
        n_checks++; if ({done, ready} !== 2'b01) begin n_fail++; $display("FAIL g1_pulse got done=%b ready=%b want 0 1", done, ready); end
    endtask

    task automatic test_skip();
        run_op(12'o7450, 12'o0005, 1'b0, 12'o7777, 12'o0);
        n_checks++; if (pc_out !== 12'o0001) begin n_fail++; $display("FAIL sna_wrap got %o want 0001", pc_out); end
        run_op(12'o7450, 12'o0000, 1'b0, 12'o7777, 12'o0);
        n_checks++; if (pc_out !== 12'o0000) begin n_fail++; $display("FAIL sna_noskip got %o want 0000", pc_out); end
    endtask

    task automatic test_osr_halt();
        logic seen = 1'b0;
        run_op(12'o7604, 12'o1234, 1'b1, 12'o0400, 12'o0707);
        n_checks++; if ({ac_out, l_out, pc_out} !== {12'o0707, 1'b1, 12'o0401}) begin n_fail++; $display("FAIL cla_osr got ac=%o l=%b pc=%o want 0707 1 0401", ac_out, l_out, pc_out); end
        run_op(12'o7402, 12'o0055, 1'b0, 12'o0500, 12'o0);
        n_checks++; if ({lat, ac_out, pc_out} !== {32'd3, 12'o0055, 12'o0501}) begin n_fail++; $display("FAIL hlt_result got lat=%0d ac=%o pc=%o want 3 0055 0501", lat, ac_out, pc_out); end
        @(posedge clk); #1;
        n_checks++; if ({halted, ready} !== 2'b10) begin n_fail++; $display("FAIL hlt_state got halted=%b ready=%b want 1 0", halted, ready); end
        ir = 12'o7301; start = 1'b1;
        repeat (4) begin @(posedge clk); #1; seen |= done; end
        start = 1'b0;
        n_checks++; if ({halted, seen} !== 2'b10) begin n_fail++; $display("FAIL hlt_ignore got halted=%b done_seen=%b want 1 0", halted, seen); end
        cont = 1'b1;
        @(posedge clk); #1; cont = 1'b0;
        n_checks++; if ({halted, ready} !== 2'b01) begin n_fail++; $display("FAIL hlt_cont got halted=%b ready=%b want 0 1", halted, ready); end
    endtask

    task automatic test_back_to_back();
        run_op(12'o7421, 12'o1234, 1'b0, 12'o0600, 12'o0);
        n_checks++; if ({mq_out, ac_out, pc_out} !== {12'o1234, 12'o0000, 12'o0601}) begin n_fail++; $display("FAIL mql got mq=%o ac=%o pc=%o want 1234 0000 0601", mq_out, ac_out, pc_out); end
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", ready); end
        run_op(12'o7501, 12'o0040, 1'b0, 12'o0601, 12'o0);
        n_checks++; if ({lat, ac_out, mq_out} !== {32'd3, 12'o1274, 12'o1234}) begin n_fail++; $display("FAIL mqa got lat=%0d ac=%o mq=%o want 3 1274 1234", lat, ac_out, mq_out); end
    endtask

    task automatic test_illegal();
        run_op(12'o5123, 12'o3333, 1'b1, 12'o0100, 12'o0);
        n_checks++; if ({lat, illegal} !== {32'd2, 1'b1}) begin n_fail++; $display("FAIL jmp_illegal got lat=%0d ill=%b want 2 1", lat, illegal); end
        n_checks++; if ({ac_out, l_out, pc_out, mq_out} !== {12'o3333, 1'b1, 12'o0101, 12'o1234}) begin n_fail++; $display("FAIL jmp_regs got ac=%o l=%b pc=%o mq=%o want 3333 1 0101 1234", ac_out, l_out, pc_out, mq_out); end
        kill = 1'b1;
        run_op(12'o7301, 12'o0070, 1'b1, 12'o0300, 12'o0);
        kill = 1'b0;
        n_checks++; if ({lat, illegal, ac_out, l_out, pc_out} !== {32'd3, 1'b1, 12'o0070, 1'b1, 12'o0301}) begin n_fail++; $display("FAIL no_group got lat=%0d ill=%b ac=%o l=%b pc=%o want 3 1 0070 1 0301", lat, illegal, ac_out, l_out, pc_out); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        @(posedge clk); #1;
        ir = 12'o7421; ac_in = 12'o7777; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({ready, done, mq_out, ac_out} !== {1'b1, 1'b0, 12'o0, 12'o0}) begin n_fail++; $display("FAIL mid_reset got ready=%b done=%b mq=%o ac=%o want 1 0 0 0", ready, done, mq_out, ac_out); end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; seen |= done; end
        n_checks++; if ({seen, mq_out} !== {1'b0, 12'o0}) begin n_fail++; $display("FAIL mid_abort got done_seen=%b mq=%o want 0 0", seen, mq_out); end
    endtask

    initial begin
        test_reset();
        test_group1();
        test_skip();
        test_osr_halt();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
